sprite_mover: RTL and testbench
===============================

# sprite_mover

Parametrised single-sprite animator for the 160x120 VGA adapter path. It repeats a fixed sequence for a BOX_W x BOX_H rectangle: draw in the foreground colour, wait a programmable number of frame ticks, erase in the background colour, then advance the position. Motion is diagonal, with edge bounce or wrap-around. Outputs drive the vga_adapter x/y/colour/plot inputs directly; the block sits between top level and adapter.

## Interface
- SCREEN_W, 160: screen width in pixels.
- SCREEN_H, 120: screen height in pixels.
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- BOX_W, 4: sprite width; range 1..16.
- BOX_H, 4: sprite height; range 1..16.
- STEP_X, 1: x displacement per move.
- STEP_Y, 1: y displacement per move.
- INIT_X, 0: x position after reset.
- INIT_Y, 50: y position after reset.
- FRAME_DIV, 833333: clk cycles per frame tick.
- FRAMES_PER_STEP, 4: frame ticks between draw and erase.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  allows leaving S_WAIT; low pauses with the sprite visible.
- fg_colour  in  3  draw colour.
- bg_colour  in  3  erase colour.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- step_done  out  1  one-cycle pulse when the position updates.

## Operation
- States: S_LOAD, S_DRAW, S_WAIT, S_ERASE, S_UPDATE.
- S_LOAD: lasts 1 cycle. Latches pos_x/pos_y into org_x/org_y, clears the pixel counter. Next state is S_DRAW.
- S_DRAW: lasts BOX_W*BOX_H cycles, with plot=1 and colour=fg_colour.
  - Pixels are scanned row-major: col counts 0..BOX_W-1 (inner), row counts 0..BOX_H-1.
  - x=org_x+col, y=org_y+row.
  - The cycle with the last pixel moves the FSM to S_WAIT.
- S_WAIT: plot=0.
  - frame_cnt increments on every frame tick seen while in S_WAIT, and saturates at FRAMES_PER_STEP.
  - Leave to S_ERASE on the first cycle where frame_cnt==FRAMES_PER_STEP and enable=1.
  - frame_cnt clears on exit.
- S_ERASE: identical to S_DRAW, except colour=bg_colour. Next state is S_UPDATE.
- S_UPDATE: lasts 1 cycle. Computes the new position, sets step_done=1. Next state is S_LOAD.
- Limits: MAX_X=SCREEN_W-BOX_W, MAX_Y=SCREEN_H-BOX_H.
- Arithmetic is done at X_W+1 / Y_W+1 bits so overflow cannot wrap silently.
- Direction bits dir_x/dir_y: 0 means +, 1 means -. Both reset to 0.
- Update rules: see Configuration.
- enable and the colour inputs are sampled continuously. A draw or erase pass is never interrupted by enable=0.
- Frame tick: a free-running divider counts 0..FRAME_DIV-1 and pulses for 1 cycle at FRAME_DIV-1.
  - It is unaffected by FSM state.
  - It is reset only by reset_n.

## Timing
- Reset (reset_n=0 at a clk edge) produces, on the next cycle:
  - state=S_LOAD;
  - x=0, y=0, colour=0, plot=0, step_done=0;
  - pos=(INIT_X,INIT_Y), dir=(0,0);
  - all counters cleared.
- Reset mid-pass drops plot on the following cycle. Pixels already written are not erased.
- All outputs are decoded from registered state and counters. There is no combinational path from any input to any output except colour, which follows the colour inputs.
- Cycles from S_LOAD entry to first plot: 1.
- Minimum period per move: 2*BOX_W*BOX_H + 2 cycles, plus the S_WAIT dwell.
- A frame tick in the same cycle as S_WAIT entry is counted.
- A frame tick in the same cycle as S_WAIT exit is discarded.

## Configuration
- Macro: SPRITE_MOVER_BOUNCE_EN.
- Defined (bounce):
  - If pos+step would exceed MAX (dir=0), or would go below 0 (dir=1), clamp to MAX or 0 and toggle dir.
  - Otherwise pos ±= step.
  - Axes are handled independently.
- Undefined (wrap):
  - dir is held at 0.
  - If pos+step > MAX, then pos = pos+step-(MAX+1); otherwise pos += step.

## Structure
- Package sprite_pkg holds:
  - the state enum;
  - COLOUR_W=3;
  - the default SCREEN_W/SCREEN_H constants.
- Sub-module frame_tick_gen holds the FRAME_DIV divider, parameterised on FRAME_DIV, with output tick.

## Test plan
Bench settings: FRAME_DIV=4, FRAMES_PER_STEP=2, 4x4 box, fg=7, bg=0.
- Pass order after reset: release reset; expect 16 plot cycles with colour=7, covering (0,50)..(3,53) row-major; then an erase pass at the same pixels with colour=0; then step_done; the next draw origin is (1,51).
- Pause: hold enable=0 for 50 cycles after the draw. Expect plot=0 throughout. Raise enable: erase starts within 1 cycle.
- Right edge: set INIT_X=156, STEP_X=1.
  - With bounce: next origin x=156 clamped, dir_x=1, then 155.
  - With wrap: next origin x=0.
- Bottom edge with bounce: set INIT_Y=116. Expect y to clamp at 116, then go 115, 114...
- Mid-pass reset: assert reset_n=0 at pixel 7 of a draw. Next cycle plot=0, x=0, y=0. After release the first draw starts at (INIT_X,INIT_Y).
- Move period check: measure cycles between consecutive step_done pulses. It must equal 34 plus the S_WAIT dwell, with the dwell consistent with FRAME_DIV=4.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite_mover slice.
//   state_t      - sprite_mover FSM state encoding
//   COLOUR_W     - width of the adapter colour bus
//   SCREEN_W_DEF - default screen width (pixels)
//   SCREEN_H_DEF - default screen height (pixels)
package sprite_pkg;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_DRAW   = 3'd1,
    S_WAIT   = 3'd2,
    S_ERASE  = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  localparam int COLOUR_W     = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running divider producing a one-cycle frame tick.
//   clk     in  clock
//   reset_n in  synchronous active-low reset (clears the divider)
//   tick    out high for one cycle when the divider reaches FRAME_DIV-1
// The divider ignores everything except reset, so tick phase is fixed
// relative to the last reset release.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)             cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: single BOX_W x BOX_H sprite animator for the vga_adapter.
// Repeats: load origin, draw (fg), wait FRAMES_PER_STEP frame ticks,
// erase (bg), update position. Diagonal motion.
//   Build option SPRITE_MOVER_BOUNCE_EN: defined -> edge bounce,
//   undefined -> wrap-around (direction bits held at 0).
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   enable               allows leaving S_WAIT (pause keeps sprite visible)
//   fg_colour, bg_colour draw / erase colours (passed through combinationally)
//   x, y, colour, plot   pixel write to the vga_adapter
//   step_done            one-cycle pulse while the position updates
//   state_dbg            current FSM state
//   dir_dbg              {dir_y, dir_x}; 0 = increasing, 1 = decreasing
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int BOX_W           = 4,
  parameter int BOX_H           = 4,
  parameter int STEP_X          = 1,
  parameter int STEP_Y          = 1,
  parameter int INIT_X          = 0,
  parameter int INIT_Y          = 50,
  parameter int FRAME_DIV       = 833333,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                step_done,
  output state_t              state_dbg,
  output logic [1:0]          dir_dbg
);

  localparam logic [3:0]     COL_LAST = 4'(BOX_W - 1);
  localparam logic [3:0]     ROW_LAST = 4'(BOX_H - 1);
  // Position maths is one bit wider so pos+step cannot wrap unnoticed.
  localparam logic [X_W:0]   MAX_X    = (X_W+1)'(SCREEN_W - BOX_W);
  localparam logic [Y_W:0]   MAX_Y    = (Y_W+1)'(SCREEN_H - BOX_H);
  localparam logic [X_W:0]   STEP_XW  = (X_W+1)'(STEP_X);
  localparam logic [Y_W:0]   STEP_YW  = (Y_W+1)'(STEP_Y);
  localparam int             FC_W     = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [FC_W-1:0] FC_TOP  = FC_W'(FRAMES_PER_STEP);

  state_t          state, state_nxt;
  logic [X_W-1:0]  pos_x, org_x, nxt_x;
  logic [Y_W-1:0]  pos_y, org_y, nxt_y;
  logic            dir_x, dir_y, nxt_dir_x, nxt_dir_y;
  logic [3:0]      col, row;
  logic [FC_W-1:0] frame_cnt;
  logic            tick, last_pix, in_pass;
  logic [X_W:0]    sum_x;
  logic [Y_W:0]    sum_y;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign in_pass  = (state == S_DRAW) || (state == S_ERASE);
  assign sum_x    = {1'b0, pos_x} + STEP_XW;
  assign sum_y    = {1'b0, pos_y} + STEP_YW;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD:   state_nxt = S_DRAW;
      S_DRAW:   if (last_pix) state_nxt = S_WAIT;
      S_WAIT:   if ((frame_cnt == FC_TOP) && enable) state_nxt = S_ERASE;
      S_ERASE:  if (last_pix) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // Next position and direction, consumed only in S_UPDATE.
  always_comb begin
    nxt_x     = pos_x;
    nxt_y     = pos_y;
    nxt_dir_x = dir_x;
    nxt_dir_y = dir_y;
`ifdef SPRITE_MOVER_BOUNCE_EN
    if (!dir_x) begin
      if (sum_x > MAX_X) begin nxt_x = MAX_X[X_W-1:0]; nxt_dir_x = 1'b1; end
      else                     nxt_x = sum_x[X_W-1:0];
    end else begin
      if ({1'b0, pos_x} < STEP_XW) begin nxt_x = '0; nxt_dir_x = 1'b0; end
      else                               nxt_x = pos_x - STEP_XW[X_W-1:0];
    end
    if (!dir_y) begin
      if (sum_y > MAX_Y) begin nxt_y = MAX_Y[Y_W-1:0]; nxt_dir_y = 1'b1; end
      else                     nxt_y = sum_y[Y_W-1:0];
    end else begin
      if ({1'b0, pos_y} < STEP_YW) begin nxt_y = '0; nxt_dir_y = 1'b0; end
      else                               nxt_y = pos_y - STEP_YW[Y_W-1:0];
    end
`else
    // Wrap: subtracting MAX+1 lands the overshoot back at the left/top edge.
    nxt_dir_x = 1'b0;
    nxt_dir_y = 1'b0;
    if (sum_x > MAX_X) nxt_x = pos_x + STEP_XW[X_W-1:0] - MAX_X[X_W-1:0] - X_W'(1);
    else               nxt_x = sum_x[X_W-1:0];
    if (sum_y > MAX_Y) nxt_y = pos_y + STEP_YW[Y_W-1:0] - MAX_Y[Y_W-1:0] - Y_W'(1);
    else               nxt_y = sum_y[Y_W-1:0];
`endif
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_x     <= X_W'(INIT_X);
      pos_y     <= Y_W'(INIT_Y);
      org_x     <= '0;
      org_y     <= '0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      col       <= '0;
      row       <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          org_x <= pos_x;
          org_y <= pos_y;
          col   <= '0;
          row   <= '0;
        end
        S_DRAW, S_ERASE: begin
          // Row-major scan; the row wraps to 0 on the last pixel so the
          // following pass starts clean.
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        S_WAIT: begin
          // A tick in the exit cycle is dropped: the count clears instead.
          if (state_nxt != S_WAIT)                 frame_cnt <= '0;
          else if (tick && (frame_cnt != FC_TOP))  frame_cnt <= frame_cnt + FC_W'(1);
        end
        S_UPDATE: begin
          pos_x <= nxt_x;
          pos_y <= nxt_y;
          dir_x <= nxt_dir_x;
          dir_y <= nxt_dir_y;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; only colour sees the inputs.
  always_comb begin
    x         = '0;
    y         = '0;
    colour    = '0;
    plot      = 1'b0;
    step_done = (state == S_UPDATE);
    if (in_pass) begin
      x      = org_x + X_W'(col);
      y      = org_y + Y_W'(row);
      plot   = 1'b1;
      colour = (state == S_DRAW) ? fg_colour : bg_colour;
    end
  end

  assign state_dbg = state;
  assign dir_dbg   = {dir_y, dir_x};

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed bench for sprite_mover with FRAME_DIV=4,
// FRAMES_PER_STEP=2, 4x4 box, fg=7, bg=0. Three instances share inputs:
//   u_a origin (0,50), u_b origin (156,50), u_c origin (0,116).
module tb_sprite_mover;
  import sprite_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic [2:0] fg      = 3'd7;
  logic [2:0] bg      = 3'd0;

  logic [7:0] xa, xb, xc;
  logic [6:0] ya, yb, yc;
  logic [2:0] ca, cb, cc;
  logic       pa, pb, pc, sa, sb, sc;
  state_t     sta, stb, stc;
  logic [1:0] da, db, dc;

  sprite_mover #(.FRAME_DIV(4), .FRAMES_PER_STEP(2), .INIT_X(0), .INIT_Y(50)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fg_colour(fg), .bg_colour(bg),
    .x(xa), .y(ya), .colour(ca), .plot(pa), .step_done(sa), .state_dbg(sta), .dir_dbg(da));
  sprite_mover #(.FRAME_DIV(4), .FRAMES_PER_STEP(2), .INIT_X(156), .INIT_Y(50)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fg_colour(fg), .bg_colour(bg),
    .x(xb), .y(yb), .colour(cb), .plot(pb), .step_done(sb), .state_dbg(stb), .dir_dbg(db));
  sprite_mover #(.FRAME_DIV(4), .FRAMES_PER_STEP(2), .INIT_X(0), .INIT_Y(116)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fg_colour(fg), .bg_colour(bg),
    .x(xc), .y(yc), .colour(cc), .plot(pc), .step_done(sc), .state_dbg(stc), .dir_dbg(dc));

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [14:0] exp_q[$];
  logic [14:0] got_a[$], got_b[$], got_c[$];
  int          sd_q[$];
  logic        prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  typedef struct {
    logic       en;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       sd;
  } vec_t;
  vec_t vecs[44];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; sample #1 after the edge and record draw-pass
  // origins (rising plot with fg colour) and step_done cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pa && !prev_a && ca == fg) got_a.push_back({xa, ya});
    if (pb && !prev_b && cb == fg) got_b.push_back({xb, yb});
    if (pc && !prev_c && cc == fg) got_c.push_back({xc, yc});
    prev_a = pa;
    prev_b = pb;
    prev_c = pc;
    if (sa) sd_q.push_back(cyc);
  endtask

  // Leaves the bench at cycle 0 (first sample after the last reset edge)
  // with reset_n already released for the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    cyc = 0;
    got_a.delete();
    got_b.delete();
    got_c.delete();
    sd_q.delete();
    reset_n = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] g;
    logic [14:0] e;

    // Expected cycle-by-cycle trace of instance A for its first move.
    for (int c = 0; c < 44; c++)
      vecs[c] = '{en: 1'b1, plot: 1'b0, x: 8'd0, y: 7'd0, colour: 3'd0, sd: 1'b0};
    for (int i = 0; i < 16; i++) begin
      vecs[1 + i].plot   = 1'b1;
      vecs[1 + i].x      = 8'(i % 4);
      vecs[1 + i].y      = 7'(50 + i / 4);
      vecs[1 + i].colour = 3'd7;
      vecs[25 + i].plot   = 1'b1;
      vecs[25 + i].x      = 8'(i % 4);
      vecs[25 + i].y      = 7'(50 + i / 4);
      vecs[25 + i].colour = 3'd0;
    end
    vecs[41].sd     = 1'b1;
    vecs[43].plot   = 1'b1;
    vecs[43].x      = 8'd1;
    vecs[43].y      = 7'd51;
    vecs[43].colour = 3'd7;

    // Pass order after reset
    do_reset();
    check("reset_state_a", sta, S_LOAD);
    check("reset_state_b", stb, S_LOAD);
    check("reset_state_c", stc, S_LOAD);
    check("reset_dir_a", da, 2'b00);
    for (int c = 0; c < 44; c++) begin
      if (c > 0) tick();
      check($sformatf("plot[%0d]", c), pa, vecs[c].plot);
      check($sformatf("step_done[%0d]", c), sa, vecs[c].sd);
      if (c == 41) begin
        check("step_done_b", sb, 1'b1);
        check("step_done_c", sc, 1'b1);
      end
      if (vecs[c].plot || c == 0) begin
        check($sformatf("x[%0d]", c), xa, vecs[c].x);
        check($sformatf("y[%0d]", c), ya, vecs[c].y);
        check($sformatf("colour[%0d]", c), ca, vecs[c].colour);
      end
      enable = vecs[c].en;
    end

    // Three moves: origins, edges and move period
    while (cyc < 130) tick();

    exp_q.push_back({8'd0, 7'd50});
    exp_q.push_back({8'd1, 7'd51});
    exp_q.push_back({8'd2, 7'd52});
`ifdef SPRITE_MOVER_BOUNCE_EN
    exp_q.push_back({8'd156, 7'd50});
    exp_q.push_back({8'd156, 7'd51});
    exp_q.push_back({8'd155, 7'd52});
    exp_q.push_back({8'd0, 7'd116});
    exp_q.push_back({8'd1, 7'd116});
    exp_q.push_back({8'd2, 7'd115});
    check("dir_b", db, 2'b01);
    check("dir_c", dc, 2'b10);
`else
    exp_q.push_back({8'd156, 7'd50});
    exp_q.push_back({8'd0, 7'd51});
    exp_q.push_back({8'd1, 7'd52});
    exp_q.push_back({8'd0, 7'd116});
    exp_q.push_back({8'd1, 7'd0});
    exp_q.push_back({8'd2, 7'd1});
    check("dir_b", db, 2'b00);
    check("dir_c", dc, 2'b00);
`endif
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = (k < got_a.size()) ? 32'(got_a[k]) : '1;
      check($sformatf("origin_a[%0d]", k), g, 32'(e));
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = (k < got_b.size()) ? 32'(got_b[k]) : '1;
      check($sformatf("origin_b[%0d]", k), g, 32'(e));
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = (k < got_c.size()) ? 32'(got_c[k]) : '1;
      check($sformatf("origin_c[%0d]", k), g, 32'(e));
    end

    // 34 cycles of passes plus a steady-state dwell of 6 (FRAME_DIV=4).
    check("step_count", (sd_q.size() >= 3) ? 1 : 0, 1);
    if (sd_q.size() >= 3) begin
      check("first_step_cycle", sd_q[0], 41);
      check("period_1", sd_q[1] - sd_q[0], 40);
      check("period_2", sd_q[2] - sd_q[1], 40);
    end

    // Pause with the sprite visible
    enable = 1'b0;
    do_reset();
    repeat (16) tick();
    for (int c = 0; c < 50; c++) begin
      tick();
      check($sformatf("pause_plot[%0d]", c), pa, 1'b0);
    end
    enable = 1'b1;
    tick();
    check("resume_plot", pa, 1'b1);
    check("resume_colour", ca, 3'd0);
    check("resume_x", xa, 8'd0);
    check("resume_y", ya, 7'd50);

    // Reset in the middle of a draw pass
    do_reset();
    repeat (8) tick();
    check("mid_pix7_plot", pa, 1'b1);
    check("mid_pix7_x", xa, 8'd3);
    check("mid_pix7_y", ya, 7'd51);
    reset_n = 1'b0;
    tick();
    check("mid_reset_plot", pa, 1'b0);
    check("mid_reset_x", xa, 8'd0);
    check("mid_reset_y", ya, 7'd0);
    check("mid_reset_state", sta, S_LOAD);
    reset_n = 1'b1;
    tick();
    check("restart_plot", pa, 1'b1);
    check("restart_x", xa, 8'd0);
    check("restart_y", ya, 7'd50);
    check("restart_colour", ca, 3'd7);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
